conv_linebuf_sched: RTL



---
 rtl/conv_linebuf_sched_if.sv | 29 ++
 rtl/conv_linebuf_sched.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/conv_linebuf_sched_if.sv
// Pixel-source, window-sink and status signals of the line-buffer scheduler.
interface conv_linebuf_sched_if #(
  parameter int unsigned CW = 4
) ();
  logic          start;
  logic [7:0]    img_h;
  logic          pix_valid;
  logic          pix_ready;
  logic [3:0]    we;
  logic [3:0]    oe;
  logic          win_ready;
  logic          win_valid;
  logic [CW-1:0] win_col;
  logic [1:0]    top_sel;
  logic          busy;
  logic          frame_done;

  // Controller side: frame control, pixel source and window sink.
  modport master (
    output start, img_h, pix_valid, win_ready,
    input  pix_ready, we, oe, win_valid, win_col, top_sel, busy, frame_done
  );

  // Scheduler side.
  modport slave (
    input  start, img_h, pix_valid, win_ready,
    output pix_ready, we, oe, win_valid, win_col, top_sel, busy, frame_done
  );
endinterface

// File: rtl/conv_linebuf_sched.sv
// Four-buffer line scheduler for the 3x3 convolution core: rotates incoming
// rows across the buffers and issues three-row column reads once a window
// of rows is resident, overlapping the next row's write with the read pass.
module conv_linebuf_sched #(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_linebuf_sched_if.slave  bus
);

  localparam int unsigned RW       = 8;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] h_q, h_d;
  logic [RW-1:0] wr_row_q, wr_row_d;
  logic [CW-1:0] wr_col_q, wr_col_d;
  logic [RW-1:0] base_q, base_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic          win_valid_q, win_valid_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic [1:0]    top_sel_q, top_sel_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  // Handshake-timed strobes; these follow the handshake in the same cycle.
  logic          pix_ready_c;
  logic [3:0]    we_c;
  logic [3:0]    oe_c;
  logic          writer_act;
  logic [RW:0]   base_ext;
  logic [RW:0]   wr_row_nx_ext;

  // Next-state, counter and strobe decode for writer and reader.
  always_comb begin
    state_d       = state_q;
    h_d           = h_q;
    wr_row_d      = wr_row_q;
    wr_col_d      = wr_col_q;
    base_d        = base_q;
    rd_col_d      = rd_col_q;
    win_valid_d   = 1'b0;
    win_col_d     = win_col_q;
    top_sel_d     = top_sel_q;
    pix_ready_c   = 1'b0;
    we_c          = '0;
    oe_c          = '0;
    base_ext      = {1'b0, base_q};
    writer_act    = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_WAIT);

    // Writer: stay inside the frame and never lap the oldest row being read.
    if (writer_act && (wr_row_q < h_q) && ({1'b0, wr_row_q} < base_ext + 9'd4)) begin
      pix_ready_c = 1'b1;
    end
    if (pix_ready_c && bus.pix_valid) begin
      we_c[wr_row_q[1:0]] = 1'b1;
      if (wr_col_q == LAST_COL) begin
        wr_col_d = '0;
        wr_row_d = wr_row_q + RW'(1);
      end else begin
        wr_col_d = wr_col_q + CW'(1);
      end
    end
    wr_row_nx_ext = {1'b0, wr_row_d};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          h_d      = bus.img_h;
          wr_row_d = '0;
          wr_col_d = '0;
          base_d   = '0;
          rd_col_d = '0;
          state_d  = (bus.img_h >= 8'd3) ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (wr_row_d >= 8'd3) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.win_ready) begin
          oe_c[base_q[1:0]]         = 1'b1;
          oe_c[base_q[1:0] + 2'd1]  = 1'b1;
          oe_c[base_q[1:0] + 2'd2]  = 1'b1;
          win_valid_d = 1'b1;
          win_col_d   = rd_col_q;
          top_sel_d   = base_q[1:0];
          if (rd_col_q == LAST_COL) begin
            rd_col_d = '0;
            base_d   = base_q + RW'(1);
            if (base_ext + 9'd2 == {1'b0, h_q} - 9'd1) begin
              state_d = S_DONE;
            end else if (wr_row_nx_ext >= base_ext + 9'd4) begin
              state_d = S_RUN;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            rd_col_d = rd_col_q + CW'(1);
          end
        end
      end
      S_WAIT: begin
        if (wr_row_nx_ext >= base_ext + 9'd3) state_d = S_RUN;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      h_q          <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      base_q       <= '0;
      rd_col_q     <= '0;
      win_valid_q  <= 1'b0;
      win_col_q    <= '0;
      top_sel_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      base_q       <= base_d;
      rd_col_q     <= rd_col_d;
      win_valid_q  <= win_valid_d;
      win_col_q    <= win_col_d;
      top_sel_q    <= top_sel_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.we         = we_c;
  assign bus.oe         = oe_c;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.top_sel    = top_sel_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
